led_pattern_player: RTL and testbench

Drives the TinyFPGA BX user LED (16 MHz `CLK`) with a programmable blink pattern, so a raw counter bit no longer sets the LED directly. A controller loads a 32-bit pattern through a valid/ready handshake. The block plays the pattern one bit per time slot, dims lit slots with an 8-bit PWM, and can repeat the pattern a set number of times or forever. It is the final stage before the `LED` pin.

---
 rtl/led_pattern_player_pkg.sv | 6 +
 rtl/led_pattern_player_pwm.sv | 28 ++
 rtl/led_pattern_player.sv | 115 +++++++++++
 tb/tb_led_pattern_player.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/led_pattern_player_pkg.sv
// led_pattern_player_pkg: shared state encodings and widths for the LED pattern player
package led_pattern_player_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} state_e;
  localparam int PAT_W = 32;
  localparam int PWM_W = 8;
endpackage

// File: rtl/led_pattern_player_pwm.sv
// led_pwm: free-running 8-bit PWM whose duty is captured at the start of each period
module led_pwm
  import led_pattern_player_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PWM_W-1:0] bright,
  output logic             on
);
  logic [PWM_W-1:0] cnt_q, cnt_d, bright_q, bright_d;
  always_comb begin
    cnt_d    = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    // the capture cycle already uses the new duty so period 0 is not stale
    bright_d = (cnt_q == '0) ? bright : bright_q;
    on       = cnt_q < bright_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bright_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
    end
  end
endmodule

// File: rtl/led_pattern_player.sv
// led_pattern_player: plays a loaded 32-bit blink pattern on the LED, one bit per slot,
// PWM-dimmed, with optional repetitions separated by dark gaps.
module led_pattern_player
  import led_pattern_player_pkg::*;
#(
  parameter int SLOT_CYCLES = 2_000_000,
  parameter int GAP_SLOTS   = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PAT_VALID,
  output logic             PAT_READY,
  input  logic [PAT_W-1:0] PAT_DATA,
  input  logic [4:0]       PAT_LEN,
  input  logic [3:0]       PAT_REPEAT,
  input  logic [PWM_W-1:0] BRIGHT,
  input  logic             STOP,
  output logic             LED,
  output logic             BUSY,
  output logic             DONE
);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int GW = GAP_SLOTS > 1 ? $clog2(GAP_SLOTS) : 1;
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [4:0]       len_q, len_d, idx_q, idx_d;
  logic [3:0]       rep_q, rep_d, reps_left_q, reps_left_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             led_q, led_d, done_q, done_d;
  logic             accept, slot_wrap, pass_end, gap_end, pwm_on;
  assign accept    = PAT_VALID && state_q == ST_IDLE && !STOP;
  assign slot_wrap = slot_q == SW'(SLOT_CYCLES - 1);
  assign pass_end  = state_q == ST_PLAY && slot_wrap && idx_q == len_q;
  assign gap_end   = state_q == ST_GAP && slot_wrap && gap_q == GW'(GAP_SLOTS - 1);
  assign PAT_READY = state_q == ST_IDLE;
  assign BUSY      = state_q != ST_IDLE;
  assign LED       = led_q;
  assign DONE      = done_q;
  led_pwm u_pwm (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (state_q != ST_IDLE),
    .clr   (accept),
    .bright(BRIGHT),
    .on    (pwm_on)
  );
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    rep_d       = rep_q;
    reps_left_d = reps_left_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    slot_d      = (state_q == ST_IDLE) ? slot_q : slot_wrap ? '0 : slot_q + 1'b1;
    led_d       = state_q == ST_PLAY && !STOP && pat_q[idx_q] && pwm_on;
    if (STOP) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d     = ST_PLAY;
      pat_d       = PAT_DATA;
      len_d       = PAT_LEN;
      rep_d       = PAT_REPEAT;
      reps_left_d = PAT_REPEAT;
      idx_d       = '0;
      slot_d      = '0;
      gap_d       = '0;
    end else if (pass_end) begin
      if (rep_q == '0) begin
        state_d = ST_GAP;
      end else if (reps_left_q == 4'd1) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d     = ST_GAP;
        reps_left_d = reps_left_q - 4'd1;
      end
    end else if (state_q == ST_PLAY && slot_wrap) begin
      idx_d = idx_q + 5'd1;
    end else if (gap_end) begin
      state_d = ST_PLAY;
      idx_d   = '0;
      gap_d   = '0;
    end else if (state_q == ST_GAP && slot_wrap) begin
      gap_d = gap_q + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      reps_left_q <= '0;
      idx_q       <= '0;
      slot_q      <= '0;
      gap_q       <= '0;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      reps_left_q <= reps_left_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      gap_q       <= gap_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_led_pattern_player.sv
// tb_led_pattern_player: scoreboard bench; stimulus queues per-cycle expectations, a monitor pops and checks them
module tb_led_pattern_player;
  typedef struct packed {logic led; logic done; logic busy; logic ready;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, valid2 = 1'b0, stop = 1'b0;
  logic [31:0] data = '0;
  logic [4:0]  len = '0;
  logic [3:0]  rep = '0;
  logic [7:0]  bright = '0;
  logic        ready, led, busy, done, ready2, led2, busy2, done2;
  exp_t        q1[$], q2[$];
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  led_pattern_player #(.SLOT_CYCLES(4), .GAP_SLOTS(2)) dut (
    .CLK(clk), .RST_N(rst_n), .PAT_VALID(valid), .PAT_READY(ready), .PAT_DATA(data),
    .PAT_LEN(len), .PAT_REPEAT(rep), .BRIGHT(bright), .STOP(stop),
    .LED(led), .BUSY(busy), .DONE(done)
  );
  led_pattern_player #(.SLOT_CYCLES(256), .GAP_SLOTS(2)) dut_pwm (
    .CLK(clk), .RST_N(rst_n), .PAT_VALID(valid2), .PAT_READY(ready2), .PAT_DATA(data),
    .PAT_LEN(len), .PAT_REPEAT(rep), .BRIGHT(bright), .STOP(1'b0),
    .LED(led2), .BUSY(busy2), .DONE(done2)
  );
  function automatic exp_t mk(logic l, logic d, logic b, logic r);
    return '{led: l, done: d, busy: b, ready: r};
  endfunction
  task automatic chk(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("led", led, e.led);
      chk("done", done, e.done);
      chk("busy", busy, e.busy);
      chk("ready", ready, e.ready);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("pwm_led", led2, e.led);
      chk("pwm_done", done2, e.done);
      chk("pwm_busy", busy2, e.busy);
      chk("pwm_ready", ready2, e.ready);
    end
  end
  task automatic push_play(logic [31:0] d, int l, int r);
    q1.push_back(mk(0, 0, 1, 0));
    for (int p = 0; p < r; p++) begin
      for (int j = 0; j < (l + 1) * 4; j++) begin
        logic last;
        last = (p == r - 1) && (j == (l + 1) * 4 - 1);
        q1.push_back(mk(d[j/4], last, !last, last));
      end
      if (p < r - 1)
        for (int g = 0; g < 8; g++) q1.push_back(mk(0, 0, 1, 0));
    end
    q1.push_back(mk(0, 0, 0, 1));
  endtask
  task automatic drain();
    for (int i = 0; i < 3000 && (q1.size() > 0 || q2.size() > 0); i++) @(negedge clk);
    if (q1.size() > 0 || q2.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      q1.push_back(mk(0, 0, 0, 1));
      q2.push_back(mk(0, 0, 0, 1));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    @(negedge clk);
    data = 32'b101; len = 5'd2; rep = 4'd1; bright = 8'd255; valid = 1'b1;
    push_play(32'b101, 2, 1);
    @(negedge clk);
    valid = 1'b0;
    drain();
    @(negedge clk);
    rep = 4'd2; valid = 1'b1;
    push_play(32'b101, 2, 2);
    @(negedge clk);
    valid = 1'b0;
    drain();
    @(negedge clk);
    data = 32'hFFFF_FFFF; len = 5'd0; rep = 4'd1; bright = 8'h40; valid2 = 1'b1;
    q2.push_back(mk(0, 0, 1, 0));
    for (int j = 0; j < 256; j++) q2.push_back(mk(j < 64, j == 255, j != 255, j == 255));
    q2.push_back(mk(0, 0, 0, 1));
    @(negedge clk);
    valid2 = 1'b0;
    drain();
    @(negedge clk);
    data = 32'hF; len = 5'd3; rep = 4'd1; bright = 8'd255; valid = 1'b1;
    q1.push_back(mk(0, 0, 1, 0));
    repeat (5) q1.push_back(mk(1, 0, 1, 0));
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    stop = 1'b1;
    repeat (2) q1.push_back(mk(0, 0, 0, 1));
    @(negedge clk);
    stop = 1'b0;
    drain();
    @(negedge clk);
    stop = 1'b1; valid = 1'b1;
    repeat (2) q1.push_back(mk(0, 0, 0, 1));
    @(negedge clk);
    stop = 1'b0; valid = 1'b0;
    drain();
    @(negedge clk);
    data = 32'h1; len = 5'd0; rep = 4'd0; valid = 1'b1;
    q1.push_back(mk(0, 0, 1, 0));
    for (int p = 0; p < 11; p++) begin
      repeat (4) q1.push_back(mk(1, 0, 1, 0));
      repeat (8) q1.push_back(mk(0, 0, 1, 0));
    end
    repeat (2) q1.push_back(mk(1, 0, 1, 0));
    @(negedge clk);
    valid = 1'b0;
    repeat (134) @(negedge clk);
    rst_n = 1'b0;
    q1.push_back(mk(0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    q1.push_back(mk(0, 0, 0, 1));
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
